// File: rtl/clint_pkg.sv
// Shared CLINT definitions: command ops, sequencer states,
// register offsets and access size.
package clint_pkg;

    typedef enum logic [1:0] {
        OP_READ_TIME   = 2'd0,
        OP_SET_CMP     = 2'd1,
        OP_SET_CMP_REL = 2'd2,
        OP_SET_MSIP    = 2'd3
    } op_e;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_HI1,
        S_RD_LO,
        S_RD_HI2,
        S_WR_LO_MAX,
        S_WR_HI,
        S_WR_LO,
        S_WR_MSIP,
        S_RESP
    } state_e;

    localparam logic [31:0] MSIP_OFS     = 32'h0000_0000;
    localparam logic [31:0] MTIMECMP_OFS = 32'h0000_4000;
    localparam logic [31:0] MTIME_OFS    = 32'h0000_BFF8;

    localparam logic [1:0] CLINT_SIZE_WORD = 2'b10;

    // Upper word of a 64-bit CLINT register.
    function automatic logic [31:0] hi_word(input logic [31:0] ofs);
        return ofs + 32'd4;
    endfunction

endpackage

// File: rtl/clint_timer_sequencer.sv
// Sequences tear-free mtime reads, glitch-free mtimecmp writes and MSIP
// writes on the 32-bit CLINT port.
// Ports: clk/rst_n; cmd_* request; rsp_* response; clint_* bus master.
module clint_timer_sequencer
    import clint_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
    parameter int unsigned MAX_RETRY = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [63:0] cmd_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_data,
    output logic        rsp_err,
    output logic        clint_read,
    output logic        clint_write,
    output logic [31:0] clint_addr,
    output logic [1:0]  clint_size,
    output logic [31:0] clint_write_data,
    input  logic [31:0] clint_read_data
);

    localparam logic [3:0] RETRY_LIM = 4'(MAX_RETRY);

    state_e      state;
    op_e         op_q;
    logic [63:0] data_q;
    logic [63:0] target;
    logic [31:0] h1;
    logic [31:0] lo;
    logic [3:0]  retries;

    assign cmd_ready = (state == S_IDLE);

    // Bus strobes come straight from the state register so a reset
    // drops them in the same instant.
    always_comb begin
        clint_read       = 1'b0;
        clint_write      = 1'b0;
        clint_addr       = 32'h0;
        clint_write_data = 32'h0;
        unique case (state)
            S_RD_HI1, S_RD_HI2: begin
                clint_read = 1'b1;
                clint_addr = BASE_ADDR + hi_word(MTIME_OFS);
            end
            S_RD_LO: begin
                clint_read = 1'b1;
                clint_addr = BASE_ADDR + MTIME_OFS;
            end
            S_WR_LO_MAX: begin
                clint_write      = 1'b1;
                clint_addr       = BASE_ADDR + MTIMECMP_OFS;
                clint_write_data = 32'hFFFF_FFFF;
            end
            S_WR_HI: begin
                clint_write      = 1'b1;
                clint_addr       = BASE_ADDR + hi_word(MTIMECMP_OFS);
                clint_write_data = target[63:32];
            end
            S_WR_LO: begin
                clint_write      = 1'b1;
                clint_addr       = BASE_ADDR + MTIMECMP_OFS;
                clint_write_data = target[31:0];
            end
            S_WR_MSIP: begin
                clint_write      = 1'b1;
                clint_addr       = BASE_ADDR + MSIP_OFS;
                clint_write_data = {31'b0, data_q[0]};
            end
            default: ;
        endcase
        clint_size = (clint_read || clint_write) ? CLINT_SIZE_WORD : 2'b00;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            op_q      <= OP_READ_TIME;
            data_q    <= 64'h0;
            target    <= 64'h0;
            h1        <= 32'h0;
            lo        <= 32'h0;
            retries   <= 4'h0;
            rsp_valid <= 1'b0;
            rsp_data  <= 64'h0;
            rsp_err   <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        op_q    <= op_e'(cmd_op);
                        data_q  <= cmd_data;
                        target  <= cmd_data;
                        retries <= 4'h0;
                        unique case (op_e'(cmd_op))
                            OP_READ_TIME:   state <= S_RD_HI1;
                            OP_SET_CMP_REL: state <= S_RD_HI1;
                            OP_SET_CMP:     state <= S_WR_LO_MAX;
                            OP_SET_MSIP:    state <= S_WR_MSIP;
                            default:        state <= S_IDLE;
                        endcase
                    end
                end
                S_RD_HI1: begin
                    h1    <= clint_read_data;
                    state <= S_RD_LO;
                end
                S_RD_LO: begin
                    lo    <= clint_read_data;
                    state <= S_RD_HI2;
                end
                S_RD_HI2: begin
                    if (clint_read_data == h1) begin
                        if (op_q == OP_READ_TIME) begin
                            rsp_data  <= {h1, lo};
                            rsp_valid <= 1'b1;
                            state     <= S_RESP;
                        end else begin
                            target <= {h1, lo} + data_q;
                            state  <= S_WR_LO_MAX;
                        end
                    end else if (retries < RETRY_LIM) begin
                        // High word rolled over: keep the new high word
                        // and re-read the low word against it.
                        retries <= retries + 4'h1;
                        h1      <= clint_read_data;
                        state   <= S_RD_LO;
                    end else begin
                        rsp_data  <= 64'h0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
                    end
                end
                S_WR_LO_MAX: state <= S_WR_HI;
                S_WR_HI:     state <= S_WR_LO;
                S_WR_LO: begin
                    rsp_data  <= target;
                    rsp_valid <= 1'b1;
                    state     <= S_RESP;
                end
                S_WR_MSIP: begin
                    rsp_data  <= 64'h0;
                    rsp_valid <= 1'b1;
                    state     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        retries   <= 4'h0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/clint_timer_sequencer.md
Name: clint_timer_sequencer

Overview:
Command-driven controller that sequences multi-access operations on the 32-bit CLINT register port, so requesters do not have to hand-code them.
- Performs tear-free 64-bit mtime reads using a hi-lo-hi sequence with retry.
- Performs glitch-free 64-bit mtimecmp updates: lo=all-ones, then hi, then lo.
- Supports relative timer arming (mtimecmp = mtime + delta) and MSIP set/clear.
- Sits between a requester (core-side peripheral or debug module) and the CLINT memory interface; it is the only master on that interface.

Parameters:
BASE_ADDR, 32'h0200_0000, CLINT base address; must match the CLINT instance.
MAX_RETRY, 4, number of hi-mismatch retries allowed before a timed read fails (range 1..15).

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE; a command is accepted when cmd_valid && cmd_ready
cmd_op  in  2  0=READ_TIME, 1=SET_CMP, 2=SET_CMP_REL, 3=SET_MSIP
cmd_data  in  64  absolute compare value, delta, or MSIP value in bit 0; latched at accept
rsp_valid  out  1  response valid; held until rsp_ready
rsp_ready  in  1  response accept
rsp_data  out  64  READ_TIME: time; SET_CMP/SET_CMP_REL: value written to mtimecmp; SET_MSIP: 0
rsp_err  out  1  retry limit exceeded; no writes were performed
clint_read  out  1  CLINT read strobe
clint_write  out  1  CLINT write strobe
clint_addr  out  32  CLINT word address
clint_size  out  2  constant 2'b10 (word) whenever a strobe is high, else 0
clint_write_data  out  32  CLINT write data
clint_read_data  in  32  CLINT read data; combinational, sampled on the same edge as the strobe

Behaviour:
- Reset: state=IDLE; all clint_* outputs 0; rsp_valid=0, rsp_data=0, rsp_err=0, retry counter 0. cmd_ready=1 as soon as rst_n is released.
- Exactly one CLINT access per cycle. Strobes are decoded from registered state and never overlap. read_data is captured at the end of the strobe cycle.
- States: IDLE, RD_HI1, RD_LO, RD_HI2, WR_LO_MAX, WR_HI, WR_LO, WR_MSIP, RESP.
- IDLE transitions on accept:
  - READ_TIME -> RD_HI1
  - SET_CMP_REL -> RD_HI1
  - SET_CMP -> WR_LO_MAX
  - SET_MSIP -> WR_MSIP
- Read sequence:
  - RD_HI1 reads BASE+0xBFFC into h1.
  - RD_LO reads BASE+0xBFF8 into l.
  - RD_HI2 reads BASE+0xBFFC into h2.
- At RD_HI2, if h2==h1, time={h1,l}:
  - READ_TIME -> RESP.
  - SET_CMP_REL: target = time + delta, modulo 2^64 (wrap silently) -> WR_LO_MAX.
- At RD_HI2, if h2!=h1:
  - If retries < MAX_RETRY: increment retries, set h1<=h2, go to RD_LO.
  - Otherwise: set rsp_err=1, go to RESP, perform no writes.
- Write sequence:
  - WR_LO_MAX writes 0xFFFF_FFFF to BASE+0x4000.
  - WR_HI writes target[63:32] to BASE+0x4004.
  - WR_LO writes target[31:0] to BASE+0x4000.
  - Then -> RESP.
- WR_MSIP writes {31'b0, cmd_data[0]} to BASE+0x0, then -> RESP.
- Latency from the accept edge T (no retries), rsp_valid first high at:
  - READ_TIME: T+4
  - SET_CMP: T+4
  - SET_MSIP: T+2
  - SET_CMP_REL: T+7
  - Each retry adds 2 cycles.
- RESP: rsp_valid=1 with rsp_data/rsp_err stable. On rsp_ready: clear rsp_valid/rsp_err, reset retries, go to IDLE. cmd_ready goes high the cycle after.
- cmd_valid while busy is ignored; the requester holds it.
- Reset mid-operation aborts immediately and deasserts all strobes. A partially written mtimecmp is left as-is; software re-issues the command.

Decomposition:
- clint_pkg holds:
  - the op enum (READ_TIME, SET_CMP, SET_CMP_REL, SET_MSIP);
  - the state enum;
  - offset constants MSIP_OFS=0x0, MTIMECMP_OFS=0x4000, MTIME_OFS=0xBFF8;
  - CLINT_SIZE_WORD=2'b10.
- The CLINT is later updated to import the offsets from clint_pkg.
- No sub-module: a single FSM with a 64-bit adder. An implementation splitting out the read path may use clint_time_reader, but this is not required.

Test Plan:
1. Mock CLINT with hi=0x1, lo=0x10 stable; READ_TIME -> bus trace is rd BFFC, rd BFF8, rd BFFC; rsp_data=0x0000_0001_0000_0010 at T+4; rsp_err=0.
2. Mock returns h1=0x1, lo=0x2, h2=0x2, then lo=0x5, h=0x2 -> one retry; rsp_data=0x0000_0002_0000_0005 at T+6.
3. SET_CMP 0x0000_0003_8000_0000 with a real CLINT (mtime≈0) -> writes (4000,FFFF_FFFF), (4004,3), (4000,8000_0000); timer_int stays 0 every cycle; rsp at T+4.
4. SET_CMP_REL delta=0x100, mock time 0x0000_0000_FFFF_FFF0 -> writes hi=0x1, lo=0x0000_00F0; rsp_data=0x0000_0001_0000_00F0 at T+7.
5. MAX_RETRY=2, mock hi increments on every read -> rsp_err=1 after 3 hi mismatches; zero clint_write pulses.
6. Hold rsp_ready=0 for 5 cycles -> rsp_valid/rsp_data stable and cmd_ready=0. Assert rst_n=0 during WR_HI -> all strobes 0 immediately; cmd_ready=1 after release.
